// File: rtl/qspi_pkg.sv
// Shared definitions for the quad-SPI flash read controller.
`timescale 1ns/1ps
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_STALLED
  } state_t;

  localparam logic [7:0] CMD_QUAD_IO_READ = 8'hEB;
  localparam logic [7:0] MODE_BYTE        = 8'h00;

  localparam int CMD_CLKS   = 8;
  localparam int ADDR_CLKS  = 6;
  localparam int MODE_CLKS  = 2;
  localparam int DUMMY_CLKS = 4;

endpackage

// File: rtl/qspi_flash_ctrl.sv
// Read-only QSPI NOR controller: issues 0xEB Fast Read Quad I/O and streams
// sequential words, with SCK pause (stall) and abort (stop).
`timescale 1ns/1ps
module qspi_flash_ctrl
  import qspi_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = 1,
  parameter int ADDR_BITS        = 24
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [3:0]                    spi_data_in,
  output logic [3:0]                    spi_data_out,
  output logic [3:0]                    spi_data_oe,
  output logic                          spi_select,
  output logic                          spi_clk_out,
  input  logic [ADDR_BITS-1:0]          addr_in,
  input  logic                          start_read,
  input  logic                          stall_read,
  input  logic                          stop_read,
  output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
  output logic                          data_ready,
  output logic                          busy
);

  localparam int WORD_W    = 8 * DATA_WIDTH_BYTES;
  localparam int HDR_W     = 40;
  localparam int SR_W      = (WORD_W > HDR_W) ? WORD_W : HDR_W;
  localparam int DATA_CLKS = 2 * DATA_WIDTH_BYTES;
  localparam int CNT_W     = $clog2(DATA_CLKS + CMD_CLKS) + 1;

  state_t            state;
  logic              sck;
  logic [CNT_W-1:0]  cnt;
  logic [SR_W-1:0]   sr;
  logic              last;
  logic [SR_W-1:0]   sr_next_data;
  logic [WORD_W-1:0] word_next;

  // cnt counts completed SCK periods within the current phase
  always_comb begin
    last = 1'b0;
    case (state)
      ST_CMD:   last = (cnt == CNT_W'(CMD_CLKS - 1));
      ST_ADDR:  last = (cnt == CNT_W'(ADDR_CLKS - 1));
      ST_MODE:  last = (cnt == CNT_W'(MODE_CLKS - 1));
      ST_DUMMY: last = (cnt == CNT_W'(DUMMY_CLKS - 1));
      ST_DATA:  last = (cnt == CNT_W'(DATA_CLKS - 1));
      default:  last = 1'b0;
    endcase
  end

  // Stream accumulates MSB-first; byte-swap so the first byte lands lowest.
  assign sr_next_data = {sr[SR_W-5:0], spi_data_in};

  always_comb begin
    word_next = '0;
    for (int i = 0; i < DATA_WIDTH_BYTES; i++)
      word_next[8*i +: 8] = sr_next_data[8*(DATA_WIDTH_BYTES-1-i) +: 8];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      sck        <= 1'b0;
      cnt        <= '0;
      sr         <= '0;
      data_out   <= '0;
      data_ready <= 1'b0;
    end else if (stop_read) begin
      state      <= ST_IDLE;
      sck        <= 1'b0;
      cnt        <= '0;
      data_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_read) begin
            state <= ST_CMD;
            sck   <= 1'b0;
            cnt   <= '0;
            sr    <= '0;
            sr[SR_W-1 -: HDR_W] <= {CMD_QUAD_IO_READ, 24'(addr_in), MODE_BYTE};
          end
        end
        ST_STALLED: begin
          if (!stall_read) begin
            state      <= ST_DATA;
            data_ready <= 1'b0;
          end
        end
        default: begin
          if (state == ST_DATA && data_ready) begin
            // SCK stays low while a word is on offer
            if (stall_read) state      <= ST_STALLED;
            else            data_ready <= 1'b0;
          end else if (!sck) begin
            sck <= 1'b1;
          end else begin
            sck <= 1'b0;
            cnt <= last ? '0 : cnt + 1'b1;
            case (state)
              ST_CMD: begin
                sr <= sr << 1;
                if (last) state <= ST_ADDR;
              end
              ST_ADDR: begin
                sr <= sr << 4;
                if (last) state <= ST_MODE;
              end
              ST_MODE: begin
                sr <= sr << 4;
                if (last) state <= ST_DUMMY;
              end
              ST_DUMMY: begin
                if (last) state <= ST_DATA;
              end
              default: begin
                sr <= sr_next_data;
                if (last) begin
                  data_out   <= word_next;
                  data_ready <= 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    spi_data_out = 4'h0;
    spi_data_oe  = 4'b0000;
    case (state)
      ST_CMD: begin
        spi_data_out = {3'b000, sr[SR_W-1]};
        spi_data_oe  = 4'b0001;
      end
      ST_ADDR, ST_MODE: begin
        spi_data_out = sr[SR_W-1 -: 4];
        spi_data_oe  = 4'b1111;
      end
      default: ;
    endcase
  end

  assign spi_select  = (state == ST_IDLE);
  assign busy        = ~spi_select;
  assign spi_clk_out = sck;

endmodule

// File: tb/tb_qspi_flash_ctrl.sv
// Bench for qspi_flash_ctrl: behavioural flash on the bus plus a word-level
// expectation model, directed timing cases and randomized stall streaming.
`timescale 1ns/1ps
module tb_qspi_flash_ctrl;

  localparam int DWB = 1;
  localparam int WW  = 8 * DWB;
  localparam int FIRST_LAT = 1 + 2 * (8 + 6 + 2 + 4 + 2 * DWB);
  localparam int SPACING   = 1 + 4 * DWB;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [3:0]    spi_data_in = 4'h0;
  logic [3:0]    spi_data_out, spi_data_oe;
  logic          spi_select, spi_clk_out;
  logic [23:0]   addr_in = '0;
  logic          start_read = 1'b0, stall_read = 1'b0, stop_read = 1'b0;
  logic [WW-1:0] data_out;
  logic          data_ready, busy;

  qspi_flash_ctrl #(.DATA_WIDTH_BYTES(DWB), .ADDR_BITS(24)) dut (
    .clk(clk), .rstn(rstn),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe),
    .spi_select(spi_select), .spi_clk_out(spi_clk_out),
    .addr_in(addr_in), .start_read(start_read), .stall_read(stall_read), .stop_read(stop_read),
    .data_out(data_out), .data_ready(data_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // flash contents: a few programmed bytes over a default address hash
  logic [7:0] mem [int];

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [WW-1:0] exp_word(input logic [23:0] a, input int w);
    logic [WW-1:0] r;
    r = '0;
    for (int i = 0; i < DWB; i++) r[8*i +: 8] = fbyte(a + 24'(w * DWB + i));
    return r;
  endfunction

  // behavioural flash: decodes by SCK count since select fell
  int         fk;
  int         fn;
  logic [7:0] f_cmd, f_mode, fb;
  logic [23:0] f_addr;
  bit         oe_bad;

  always @(negedge spi_select or posedge spi_clk_out) begin
    if (!spi_clk_out) begin
      fk = 0; f_cmd = 0; f_addr = 0; f_mode = 0; oe_bad = 0; spi_data_in = 4'h0;
    end else if (!spi_select) begin
      fk++;
      if (fk <= 8) begin
        f_cmd = {f_cmd[6:0], spi_data_out[0]};
        if (spi_data_oe != 4'b0001) oe_bad = 1;
      end else if (fk <= 14) begin
        f_addr = {f_addr[19:0], spi_data_out};
        if (spi_data_oe != 4'b1111) oe_bad = 1;
      end else if (fk <= 16) begin
        f_mode = {f_mode[3:0], spi_data_out};
        if (spi_data_oe != 4'b1111) oe_bad = 1;
      end else begin
        if (spi_data_oe != 4'b0000) oe_bad = 1;
        if (fk >= 21) begin
          fn = fk - 21;
          fb = fbyte(f_addr + 24'(fn / 2));
          spi_data_in = (fn % 2 == 0) ? fb[7:4] : fb[3:0];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [23:0] a);
    addr_in = a; start_read = 1'b1;
    tick();
    start_read = 1'b0; addr_in = 24'($urandom);
  endtask

  task automatic stop();
    stop_read = 1'b1;
    tick();
    stop_read = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (!data_ready && n < budget) begin tick(); n++; end
    if (!data_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sel"},  spi_select, 1'b1);
    chk({tag, "_sck"},  spi_clk_out, 1'b0);
    chk({tag, "_oe"},   spi_data_oe, 4'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rdy"},  data_ready, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n, w, cyc;
    logic prev;
    logic [23:0] a;

    mem[32'h100123] = 8'hA5;
    mem[32'h100124] = 8'h3C;
    mem[32'h100125] = 8'h7E;

    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_sd", spi_data_out, 4'h0);
    chk("reset_dout", data_out, '0);
    rstn = 1'b1;
    tick();

    // first transaction, unstalled three-word stream
    start(24'h100123);
    chk("c1_sel", spi_select, 1'b0);
    chk("c1_busy", busy, 1'b1);
    chk("c1_sd", spi_data_out, 4'h1);
    chk("c1_oe", spi_data_oe, 4'b0001);
    wait_ready(200, n);
    chk("first_lat", n + 1, FIRST_LAT);
    chk("w0", data_out, 8'hA5);
    chk("cmd", f_cmd, 8'hEB);
    chk("addr", f_addr, 24'h100123);
    chk("mode", f_mode, 8'h00);
    chk("dummy_sck_count", fk, 8 + 6 + 2 + 4 + 2 * DWB);
    for (int i = 1; i < 3; i++) begin
      tick();
      chk("rdy_pulse", data_ready, 1'b0);
      wait_ready(50, n);
      chk("spacing", n + 1, SPACING);
      chk("w_seq", data_out, exp_word(24'h100123, i));
    end
    chk("oe_phase", oe_bad, 1'b0);
    stop();
    chk_idle_outputs("stop1");
    chk("stop1_dout_kept", data_out, 8'h7E);
    tick();

    // stall on the first word for 20 clk
    stall_read = 1'b1;
    start(24'h100123);
    wait_ready(200, n);
    chk("stall_lat", n + 1, FIRST_LAT);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_hold", {spi_clk_out, data_ready, data_out}, {1'b0, 1'b1, 8'hA5});
    end
    stall_read = 1'b0;
    tick();
    chk("stall_release_rdy", data_ready, 1'b0);
    wait_ready(50, n);
    chk("stall_resume_spacing", n + 1, SPACING);
    chk("stall_next", data_out, 8'h3C);
    stop();
    tick();

    // stop during ADDR, with a simultaneous start that must be ignored
    a = 24'($urandom);
    start(a);
    repeat (20) tick();
    chk("in_addr_oe", spi_data_oe, 4'b1111);
    stop_read = 1'b1; start_read = 1'b1; addr_in = 24'h123456;
    tick();
    stop_read = 1'b0; start_read = 1'b0;
    chk("stop_addr_sel", spi_select, 1'b1);
    chk("stop_addr_busy", busy, 1'b0);
    tick();
    chk("stop_start_ignored", spi_select, 1'b1);
    start(24'h000000);
    wait_ready(200, n);
    chk("restart_lat", n + 1, FIRST_LAT);
    chk("restart_addr", f_addr, 24'h000000);
    chk("restart_w0", data_out, exp_word(24'h000000, 0));
    stop();
    tick();

    // start while busy must not disturb address or phase
    start(24'h100123);
    repeat (9) tick();
    addr_in = 24'h000000; start_read = 1'b1;
    tick();
    start_read = 1'b0;
    wait_ready(200, n);
    chk("busy_start_lat", n + 11, FIRST_LAT);
    chk("busy_start_addr", f_addr, 24'h100123);
    chk("busy_start_w0", data_out, 8'hA5);
    stop();
    tick();

    // random addresses with random stall patterns
    for (int t = 0; t < 4; t++) begin
      a = 24'($urandom);
      start(a);
      w = 0; prev = 1'b0; cyc = 0;
      while (w < 6 && cyc < 1000) begin
        stall_read = 1'($urandom_range(0, 1));
        tick(); cyc++;
        if (data_ready && !prev) begin
          chk("rnd_word", data_out, exp_word(a, w));
          w++;
        end
        prev = data_ready;
      end
      if (w < 6) chk("rnd_timeout", w, 6);
      chk("rnd_addr", f_addr, a);
      stall_read = 1'b0;
      stop();
      tick();
    end

    // asynchronous reset mid-DATA, SCK high at that moment
    start(24'h100123);
    repeat (48) tick();
    chk("pre_rst_sck", spi_clk_out, 1'b1);
    rstn = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_sd", spi_data_out, 4'h0);
    chk("async_rst_dout", data_out, '0);
    tick();
    rstn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qspi_flash_ctrl.md
# qspi_flash_ctrl

Read-only quad-SPI flash controller that streams sequential bytes from an external NOR flash (QSPI PMOD, CS0). It sits between the console core's cartridge-ROM fetch logic and the uio pins. It takes a 24-bit start address and issues a Fast Read Quad I/O (0xEB) transaction. It then delivers `DATA_WIDTH_BYTES` at a time, can pause the serial clock on request, and can abort the transaction at any time.

## Interface
- `DATA_WIDTH_BYTES`, default 1: bytes collected per `data_ready` word.
- `ADDR_BITS`, default 24: width of `addr_in`. Must be 24.
- `clk` in 1: system clock. SPI clock is clk/2.
- `rstn` in 1: reset, asynchronous and active-low.
- `spi_data_in` in 4: SD3..SD0 from the flash.
- `spi_data_out` out 4: SD3..SD0 to the flash.
- `spi_data_oe` out 4: per-line output enable, 1 = drive.
- `spi_select` out 1: flash chip select, active-low.
- `spi_clk_out` out 1: SPI SCK.
- `addr_in` in ADDR_BITS: start byte address. Sampled only on an accepted `start_read`.
- `start_read` in 1: begin a transaction. Honoured only when idle.
- `stall_read` in 1: hold SCK and the current data while `data_ready` is high.
- `stop_read` in 1: abort and return to idle.
- `data_out` out 8·DATA_WIDTH_BYTES: assembled word. The first byte received is in the lowest byte; the high nibble of each byte arrives first.
- `data_ready` out 1: `data_out` is valid.
- `busy` out 1: a transaction is in progress (select asserted).

## Operation
- Reset values: `spi_select`=1, `spi_clk_out`=0, `spi_data_out`=0, `spi_data_oe`=0000, `data_out`=0, `data_ready`=0, `busy`=0. State is IDLE.
- States: IDLE → CMD → ADDR → MODE → DUMMY → DATA ⇄ STALLED. STOP from any state returns to IDLE.
- Each SPI bit period lasts 2 clk:
  - Low phase: `spi_clk_out`=0 and new output data is presented.
  - High phase: `spi_clk_out`=1.
  - Input is sampled on the clk edge that ends the high phase.
- CMD: 0xEB shifted MSB first on SD0 only, 8 SCK. `oe`=0001.
- ADDR: 24-bit address, 4 bits per SCK, MSB nibble first, 6 SCK. `oe`=1111.
- MODE: 0x00 sent over 2 SCK with `oe`=1111. This value keeps continuous-read mode off.
- DUMMY: 4 SCK, `oe`=0000.
- DATA: 2 SCK per byte, `oe`=0000, nibbles shifted into `data_out`. After 2·DATA_WIDTH_BYTES SCK, `data_out` updates and `data_ready`=1.
- With `data_ready`=1:
  - If `stall_read`=1: SCK is held low, `data_out` and `data_ready` are held, state is STALLED.
  - If `stall_read`=0: `data_ready` drops on the next clk and clocking of the next sequential word begins. The address auto-increments inside the flash.
- `stop_read`:
  - Takes precedence over every other input.
  - Next clk: `spi_select`=1, SCK=0, `oe`=0000, `busy`=0, `data_ready`=0. `data_out` keeps its last value.
  - The user may pulse `start_read` in the same cycle; it is ignored because the controller is busy. A new `start_read` is accepted once idle.
- `start_read` while busy is ignored.
- `busy` is 1 from the clk after acceptance until stop.

## Timing
- Cycle 0: `start_read` accepted.
- Cycle 1: `spi_select`=0, `busy`=1, first command bit presented.
- First `data_ready` rises 1 + 2·(8+6+2+4+2·DATA_WIDTH_BYTES) clk after acceptance. This is 45 clk for DATA_WIDTH_BYTES=1.
- Unstalled streaming:
  - `data_ready` is high 1 clk per word.
  - Words are spaced 1 + 4·DATA_WIDTH_BYTES clk apart.
- Stall costs no data: resuming continues with the next nibble.
- Asynchronous reset mid-transaction forces all reset values immediately.

## Structure
- Shared package `qspi_pkg`:
  - state enum;
  - `CMD_QUAD_IO_READ`=8'hEB;
  - `MODE_BYTE`=8'h00;
  - clock counts for each phase: CMD 8, ADDR 6, MODE 2, DUMMY 4.
- Single module. One FSM with a nibble counter and one combined shift register for command, address and data. No sub-module is needed.

## Test plan
- Reset with `rstn`=0 mid-DATA → all outputs at reset values within the same cycle, `select`=1.
- `start_read`, `addr_in`=0x10_0123, behavioural flash model holding 0xA5 at that address → bus shows 0xEB on SD0, then nibbles 1,0,0,1,2,3, mode 0,0, then 4 dummy SCK. `data_ready` rises at clk 45 with `data_out`=0xA5.
- Continuous read with `stall_read`=0, bytes 0xA5, 0x3C, 0x7E → three 1-cycle `data_ready` pulses 5 clk apart with the correct data.
- `stall_read`=1 for 20 clk on the first word → SCK frozen low, `data_out`=0xA5 held. On release, the next word is 0x3C, 5 clk later.
- `stop_read` during ADDR → next clk `select`=1, `busy`=0. A new `start_read` at 0x000000 completes normally.
- `start_read` pulsed while busy → ignored, with no change to the address or phase.
